rect_scan_gen: RTL
==================

// Module: rect_scan_gen
// PURPOSE
//  Programmable 2-D region scanner; successor to the fixed raster counter.
//  Emits (x,y) coordinates of a rectangle with per-axis stride and three scan orders.
//  Output is a valid/ready stream so downstream blocks (pixel fetch, blitter, fill) can stall it.
//  Start/busy/done control; it sits between the draw command decoder and the pixel pipeline.
// PARAMETERS
//  WIDTH      640              max X extent (coordinates 0..WIDTH-1)
//  HEIGHT     480              max Y extent (coordinates 0..HEIGHT-1)
//  X_BITS     $clog2(WIDTH)    X coordinate width
//  Y_BITS     $clog2(HEIGHT)   Y coordinate width
//  STEP_BITS  4                stride field width per axis
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          synchronous reset, active-low
//  start      in   1          launch a scan; sampled only in IDLE
//  abort      in   1          cancel the scan in progress
//  mode       in   2          scan_mode_e: 0 RASTER, 1 COLUMN, 2 SERPENTINE, 3 reserved (treated as RASTER)
//  x_start    in   X_BITS     region left; y_start in Y_BITS region top
//  x_end      in   X_BITS     region right (inclusive); y_end in Y_BITS region bottom (inclusive)
//  x_step     in   STEP_BITS  X stride; y_step in STEP_BITS Y stride
//  out_x      out  X_BITS     current X
//  out_y      out  Y_BITS     current Y
//  out_sol    out  1          current beat is the first of a line (major-axis restart)
//  out_eol    out  1          current beat is the last of a line
//  out_last   out  1          current beat is the final beat of the scan
//  out_valid  out  1          coordinate valid
//  out_ready  in   1          consumer accepts the beat
//  busy       out  1          scan in progress
//  done       out  1          1-cycle pulse on completion
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; config registers 0.
//  FSM IDLE->RUN->IDLE. IDLE & start: latch all config inputs. Next cycle: busy=1, out_valid=1,
//   out_x=x_start (SERPENTINE: same), out_y=y_start, out_sol=1. Config inputs are ignored during RUN.
//  Beat transfers on out_valid & out_ready. Outputs hold stable while out_valid & !out_ready.
//  RASTER: X is minor. x+=x_step; if the result exceeds x_end (compare at X_BITS+1 width, so carry
//   means exceed), x=x_start and y+=y_step; if y exceeds y_end, the scan ends.
//  COLUMN: same as RASTER with the axes swapped (Y minor, X major).
//  SERPENTINE: stride is forced to 1 on both axes. Even lines run x_start->x_end.
//   Odd lines (line index counted from 0) run x_end->x_start. No wrap at the turn.
//  Stride 0 is treated as 1. If x_end<x_start, x_end:=x_start is latched; same rule for Y.
//  out_eol=1 when the next minor step would exceed the end (or reach the turn point in SERPENTINE).
//  out_last = out_eol & (next major step exceeds the major end).
//  Beat with out_last accepted -> next cycle: out_valid=0, busy=0, done=1 for one cycle, state IDLE.
//  A start input in the same cycle as done is honoured; the new scan starts a cycle later.
//  abort in RUN (takes priority over a same-cycle handshake) -> next cycle: IDLE, out_valid=0,
//   busy=0, done=0. abort in IDLE has no effect.
//  Reset mid-scan: immediate return to the reset state. No done pulse.
//  Throughput: 1 beat/cycle with out_ready held high. First beat is valid 1 cycle after start.
// STRUCTURE
//  scan_pkg: typedef enum logic[1:0] scan_mode_e {SCAN_RASTER, SCAN_COLUMN, SCAN_SERP}; state enum.
//  Sub-module scan_axis_step (param BITS): next value, exceed flag, direction input. Two instances.
//   The top level does the axis mux, the FSM, and the flag generation.
// TESTING
//  RASTER 0..3 x 0..1, step 1/1, ready=1 -> 8 beats (0,0)..(3,1). done exactly 1 cycle after (3,1).
//  RASTER x 0..9 step 4, y 0..4 step 2 -> x in {0,4,8}, y in {0,2,4}. 9 beats. out_last on (8,4).
//  SERPENTINE 2..4 x 0..2 -> (2,0)(3,0)(4,0)(4,1)(3,1)(2,1)(2,2)(3,2)(4,2). sol/eol correct.
//  COLUMN 0..1 x 0..2 with random ready stalls -> (0,0)(0,1)(0,2)(1,0).. ; outputs stable under stall.
//  x_end=WIDTH-1, step 15 -> no wrap-around overflow. Also degenerate x_end<x_start -> single column.
//  abort after the 3rd beat -> valid and busy low next cycle, no done. Reset mid-scan -> all outputs 0.

Source files
------------

// File: rtl/rect_scan_gen_pkg.sv
// Shared types and helpers for the rectangular region scanner.
package rect_scan_gen_pkg;

    // Scan orders; the reserved encoding 3 is folded onto RASTER by decode_mode().
    typedef enum logic [1:0] {
        SCAN_RASTER = 2'd0,
        SCAN_COLUMN = 2'd1,
        SCAN_SERP   = 2'd2
    } scan_mode_e;

    // Controller states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Map the raw mode field onto a legal scan order.
    function automatic scan_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SCAN_COLUMN;
            2'd2:    return SCAN_SERP;
            default: return SCAN_RASTER;
        endcase
    endfunction

endpackage

// File: rtl/rect_scan_gen_axis_step.sv
// One axis of the scanner: computes the next coordinate and whether that
// step would leave the [lo, hi] range. Arithmetic is one bit wider than the
// coordinate so a carry or borrow is seen as "out of range", never a wrap.
module rect_scan_gen_axis_step
#(
    parameter int BITS      = 10,
    parameter int STEP_BITS = 4
) (
    input  logic [BITS-1:0]      cur,
    input  logic [STEP_BITS-1:0] step,
    input  logic [BITS-1:0]      lo,
    input  logic [BITS-1:0]      hi,
    input  logic                 down,
    output logic [BITS-1:0]      nxt,
    output logic                 exceed
);

    logic [BITS:0] step_ext;
    logic [BITS:0] up_sum;
    logic [BITS:0] dn_diff;

    assign step_ext = (BITS+1)'(step);
    assign up_sum   = {1'b0, cur} + step_ext;
    assign dn_diff  = {1'b0, cur} - step_ext;

    // Downward steps leave the range on a borrow or when dropping below lo.
    assign nxt    = down ? dn_diff[BITS-1:0] : up_sum[BITS-1:0];
    assign exceed = down ? (dn_diff[BITS] | (dn_diff[BITS-1:0] < lo))
                         : (up_sum > {1'b0, hi});

endmodule

// File: rtl/rect_scan_gen.sv
// Programmable 2-D region scanner. Emits the (x,y) coordinates of a
// rectangle in raster, column or serpentine order on a valid/ready stream,
// with start/busy/done control towards the draw command decoder.
module rect_scan_gen
    import rect_scan_gen_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int X_BITS    = $clog2(WIDTH),
    parameter int Y_BITS    = $clog2(HEIGHT),
    parameter int STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [X_BITS-1:0]    x_start,
    input  logic [Y_BITS-1:0]    y_start,
    input  logic [X_BITS-1:0]    x_end,
    input  logic [Y_BITS-1:0]    y_end,
    input  logic [STEP_BITS-1:0] x_step,
    input  logic [STEP_BITS-1:0] y_step,
    output logic [X_BITS-1:0]    out_x,
    output logic [Y_BITS-1:0]    out_y,
    output logic                 out_sol,
    output logic                 out_eol,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    // Latched configuration.
    logic [0:0]           state;
    scan_mode_e           mode_r;
    logic [X_BITS-1:0]    xs_r, xe_r;
    logic [Y_BITS-1:0]    ys_r, ye_r;
    logic [STEP_BITS-1:0] xst_r, yst_r;

    // Scan position.
    logic [X_BITS-1:0]    cur_x;
    logic [Y_BITS-1:0]    cur_y;
    logic                 line_odd;
    logic                 sol_r;
    logic                 done_r;

    // Sanitised configuration presented at start.
    scan_mode_e           mode_in;
    logic [X_BITS-1:0]    xe_in;
    logic [Y_BITS-1:0]    ye_in;
    logic [STEP_BITS-1:0] xst_in, yst_in;

    // Axis stepper results.
    logic [X_BITS-1:0]    x_nxt;
    logic [Y_BITS-1:0]    y_nxt;
    logic                 x_exc, y_exc;
    logic                 is_col, is_serp, run;
    logic                 minor_exc, major_exc;

    // Clean up the incoming command: zero stride means 1, serpentine forces 1, empty ranges collapse.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mode_in = decode_mode(mode);
        xst_in  = x_step;
        yst_in  = y_step;
        xe_in   = x_end;
        ye_in   = y_end;
        if (mode_in == SCAN_SERP || x_step == '0) xst_in = STEP_BITS'(1);
        if (mode_in == SCAN_SERP || y_step == '0) yst_in = STEP_BITS'(1);
        if (x_end < x_start) xe_in = x_start;
        if (y_end < y_start) ye_in = y_start;
    end

    assign is_col  = (mode_r == SCAN_COLUMN);
    assign is_serp = (mode_r == SCAN_SERP);
    assign run     = (state == ST_RUN);

    rect_scan_gen_axis_step #(.BITS(X_BITS), .STEP_BITS(STEP_BITS)) u_x_axis (
        .cur    (cur_x),
        .step   (xst_r),
        .lo     (xs_r),
        .hi     (xe_r),
        .down   (is_serp & line_odd),
        .nxt    (x_nxt),
        .exceed (x_exc)
    );

    rect_scan_gen_axis_step #(.BITS(Y_BITS), .STEP_BITS(STEP_BITS)) u_y_axis (
        .cur    (cur_y),
        .step   (yst_r),
        .lo     (ys_r),
        .hi     (ye_r),
        .down   (1'b0),
        .nxt    (y_nxt),
        .exceed (y_exc)
    );

    // Column order swaps which axis is minor (within a line) and major (between lines).
    assign minor_exc = is_col ? y_exc : x_exc;
    assign major_exc = is_col ? x_exc : y_exc;

    assign out_x     = cur_x;
    assign out_y     = cur_y;
    assign out_valid = run;
    assign busy      = run;
    assign done      = done_r;
    assign out_sol   = sol_r;
    assign out_eol   = run & minor_exc;
    assign out_last  = out_eol & major_exc;

    // Controller: launch on start, advance on each accepted beat, leave on last beat or abort.
    always_ff @(posedge clk) begin
        // NOTE: state is only ever written with non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_r   <= SCAN_RASTER;
            xs_r     <= '0;
            xe_r     <= '0;
            ys_r     <= '0;
            ye_r     <= '0;
            xst_r    <= '0;
            yst_r    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            line_odd <= 1'b0;
            sol_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r   <= mode_in;
                        xs_r     <= x_start;
                        xe_r     <= xe_in;
                        ys_r     <= y_start;
                        ye_r     <= ye_in;
                        xst_r    <= xst_in;
                        yst_r    <= yst_in;
                        cur_x    <= x_start;
                        cur_y    <= y_start;
                        line_odd <= 1'b0;
                        sol_r    <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        sol_r <= 1'b0;
                        state <= ST_IDLE;
                    end else if (out_ready) begin
                        if (out_last) begin
                            sol_r  <= 1'b0;
                            done_r <= 1'b1;
                            state  <= ST_IDLE;
                        end else if (!minor_exc) begin
                            sol_r <= 1'b0;
                            if (is_col) cur_y <= y_nxt;
                            else        cur_x <= x_nxt;
                        end else begin
                            sol_r    <= 1'b1;
                            line_odd <= ~line_odd;
                            if (is_col) begin
                                cur_x <= x_nxt;
                                cur_y <= ys_r;
                            end else begin
                                cur_y <= y_nxt;
                                // Serpentine turns in place; the direction flip handles the return.
                                if (!is_serp) cur_x <= xs_r;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
